// File: rtl/alu_iter.sv
// Registered, handshaked ALU: 1-cycle basic ops, iterative shift-add MUL/MULHU, optional restoring DIVU/REMU.
// Define ALU_ITER_DIV_EN to build the divider; without it DIVU/REMU decode as undefined opcodes.

package alu_iter_pkg;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] ALU_NOP   = 4'd0;
    localparam logic [OP_W-1:0] ALU_ADD   = 4'd1;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'd2;
    localparam logic [OP_W-1:0] ALU_AND   = 4'd3;
    localparam logic [OP_W-1:0] ALU_OR    = 4'd4;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [OP_W-1:0] ALU_SLL   = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRL   = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRA   = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLT   = 4'd9;
    localparam logic [OP_W-1:0] ALU_SLTU  = 4'd10;
    localparam logic [OP_W-1:0] ALU_MUL   = 4'd11;
    localparam logic [OP_W-1:0] ALU_MULHU = 4'd12;
    localparam logic [OP_W-1:0] ALU_DIVU  = 4'd13;
    localparam logic [OP_W-1:0] ALU_REMU  = 4'd14;
endpackage

module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = OP_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [OP_WIDTH-1:0] i_opcode,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_zero,
    output logic                o_cf,
    output logic                o_busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_RESP} state_t;

    state_t                r_state, w_state_next;
    logic [OP_WIDTH-1:0]   r_op;
    logic [WIDTH-1:0]      r_a;
    logic [2*WIDTH-1:0]    r_prod, w_prod_next, w_mul_next;
    logic [SHAMT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_result, w_basic_res, w_iter_res, w_load_lo;
    logic                  r_cf, w_basic_cf, w_iter_cf;
    logic [WIDTH:0]        w_add, w_mul_sum;
    logic [SHAMT_W-1:0]    w_shamt;
    logic                  w_accept, w_iter_op, w_iter_done;

    function automatic logic f_is_iter(input logic [OP_WIDTH-1:0] op);
`ifdef ALU_ITER_DIV_EN
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
    endfunction

    assign w_accept    = (r_state == S_IDLE) && i_valid;
    assign w_iter_op   = f_is_iter(i_opcode);
    assign w_iter_done = (r_cnt == SHAMT_W'(WIDTH - 1));

    // Product register holds {accumulator, multiplier}; each step adds and shifts right one bit.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

`ifdef ALU_ITER_DIV_EN
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_div_trial, w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    // Same register reused as {remainder, dividend/quotient}; a zero divisor naturally yields all-ones and i_a.
    assign w_div_trial = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_b};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};
    assign w_prod_next = ((r_op == ALU_DIVU) || (r_op == ALU_REMU)) ? w_div_next : w_mul_next;
    assign w_load_lo   = ((i_opcode == ALU_DIVU) || (i_opcode == ALU_REMU)) ? i_a : i_b;
`else
    assign w_prod_next = w_mul_next;
    assign w_load_lo   = i_b;
`endif

    assign w_add   = {1'b0, i_a} + {1'b0, i_b};
    assign w_shamt = i_b[SHAMT_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_basic_res = '0;
        w_basic_cf  = 1'b0;
        case (i_opcode)
            ALU_NOP:  w_basic_res = i_a;
            ALU_ADD:  begin w_basic_res = w_add[WIDTH-1:0]; w_basic_cf = w_add[WIDTH]; end
            ALU_SUB:  begin w_basic_res = i_a - i_b; w_basic_cf = (i_a < i_b); end
            ALU_AND:  w_basic_res = i_a & i_b;
            ALU_OR:   w_basic_res = i_a | i_b;
            ALU_XOR:  w_basic_res = i_a ^ i_b;
            ALU_SLL:  w_basic_res = i_a << w_shamt;
            ALU_SRL:  w_basic_res = i_a >> w_shamt;
            ALU_SRA:  w_basic_res = $signed(i_a) >>> w_shamt;
            ALU_SLT:  w_basic_res = WIDTH'($signed(i_a) < $signed(i_b));
            ALU_SLTU: w_basic_res = WIDTH'(i_a < i_b);
            default:  ;
        endcase
    end

    always_comb begin
        w_iter_res = w_prod_next[WIDTH-1:0];
        w_iter_cf  = 1'b0;
        case (r_op)
            ALU_MUL:   w_iter_cf  = |w_prod_next[2*WIDTH-1:WIDTH];
            ALU_MULHU: w_iter_res = w_prod_next[2*WIDTH-1:WIDTH];
`ifdef ALU_ITER_DIV_EN
            ALU_REMU:  w_iter_res = w_prod_next[2*WIDTH-1:WIDTH];
`endif
            default:   ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_state_next = w_iter_op ? S_ITER : S_RESP;
            end
            S_ITER: begin
                o_busy = 1'b1;
                if (w_iter_done) w_state_next = S_RESP;
            end
            S_RESP: begin
                o_valid = 1'b1;
                if (i_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= '0;
            r_a      <= '0;
`ifdef ALU_ITER_DIV_EN
            r_b      <= '0;
`endif
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cf     <= 1'b0;
        end else if (w_accept) begin
            r_op   <= i_opcode;
            r_a    <= i_a;
`ifdef ALU_ITER_DIV_EN
            r_b    <= i_b;
`endif
            r_prod <= {{WIDTH{1'b0}}, w_load_lo};
            r_cnt  <= '0;
            if (!w_iter_op) begin
                r_result <= w_basic_res;
                r_cf     <= w_basic_cf;
            end
        end else if (r_state == S_ITER) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_iter_done) begin
                r_result <= w_iter_res;
                r_cf     <= w_iter_cf;
            end
        end
    end

    assign o_result = r_result;
    assign o_zero   = (r_result == '0);
    assign o_cf     = r_cf;
endmodule
